matrix_scan_capture: RTL and testbench

//  Receive end of the 8x8 LED-matrix scan bus (3-bit row select + 8-bit active-low row data).

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/scan_stable_detect.sv | 53 +++++
 rtl/matrix_scan_capture.sv | 152 +++++++++++++++
 tb/tb_matrix_scan_capture.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED-matrix scan bus: geometry, capture FSM
// states, frame bit indexing and the active-low segment levels.
package matrix_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        COLLECT = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    // Segment lines are active-low: a driven 0 lights the LED.
    localparam logic SEG_LIT   = 1'b0;
    localparam logic SEG_UNLIT = 1'b1;
    localparam logic [COLS-1:0] ROW_ALL_OFF = {COLS{SEG_UNLIT}};

    function automatic int frame_idx(input int r, input int c);
        return COLS * r + c;
    endfunction

endpackage

// File: rtl/scan_stable_detect.sv
// Synchronises the scan select/data and emits one sample strobe per select
// dwell once the select has held for STABLE_CYC cycles.
module scan_stable_detect
    import matrix_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic             clkF,
    input  logic             reset,
    input  logic [ROW_W-1:0] scan_in,
    input  logic [COLS-1:0]  seg_in,
    output logic [ROW_W-1:0] row,
    output logic [COLS-1:0]  data,
    output logic             strobe,
    output logic             changed
);

    localparam logic [7:0] STB_MAX  = 8'(STABLE_CYC);
    localparam logic [7:0] STB_LAST = 8'(STABLE_CYC - 1);

    logic [ROW_W-1:0] scan_s1, scan_s2, scan_prev;
    logic [COLS-1:0]  seg_s1, seg_s2;
    logic [7:0]       stable_cnt;

    always_ff @(posedge clkF) begin
        if (reset) begin
            scan_s1    <= '0;
            scan_s2    <= '0;
            scan_prev  <= '0;
            seg_s1     <= '0;
            seg_s2     <= '0;
            stable_cnt <= '0;
        end else begin
            scan_s1   <= scan_in;
            scan_s2   <= scan_s1;
            scan_prev <= scan_s2;
            seg_s1    <= seg_in;
            seg_s2    <= seg_s1;
            if (changed)
                stable_cnt <= '0;
            else if (stable_cnt != STB_MAX)
                stable_cnt <= stable_cnt + 8'd1;
        end
    end

    // Strobe on the cycle the counter is about to reach STABLE_CYC, so it
    // fires once per dwell and never again while saturated.
    assign changed = (scan_s2 != scan_prev);
    assign strobe  = !changed && (stable_cnt == STB_LAST);
    assign row     = scan_s2;
    assign data    = seg_s2;

endmodule

// File: rtl/matrix_scan_capture.sv
// Rebuilds the 64-bit LED frame from the multiplexed row scan, checks row
// order and flags a stalled scan driver.
module matrix_scan_capture
    import matrix_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                   clkF,
    input  logic                   reset,
    input  logic                   en,
    input  logic [ROW_W-1:0]       scan_in,
    input  logic [COLS-1:0]        seg_in,
    output logic [ROWS*COLS-1:0]   frame,
    output logic                   frame_valid,
    output logic [ROWS-1:0]        row_mask,
    output logic                   scan_err,
    output logic                   stalled
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

    logic [ROW_W-1:0] row;
    logic [COLS-1:0]  data;
    logic             strobe, changed, timeout;

    state_t                      state, state_n;
    logic [ROW_W-1:0]            exp_row, exp_row_n;
    logic [ROWS-1:0][COLS-1:0]   shadow, shadow_n;
    logic [ROWS-1:0]             mask_n;
    logic [ROWS*COLS-1:0]        frame_n;
    logic                        fv_n, err_n, stalled_n;
    logic [TW-1:0]               stall_tmr;

    scan_stable_detect #(
        .STABLE_CYC(STABLE_CYC)
    ) u_detect (
        .clkF    (clkF),
        .reset   (reset),
        .scan_in (scan_in),
        .seg_in  (seg_in),
        .row     (row),
        .data    (data),
        .strobe  (strobe),
        .changed (changed)
    );

    assign timeout = !changed && (stall_tmr == TMR_LAST);

    always_ff @(posedge clkF) begin
        if (reset) begin
            state       <= IDLE;
            exp_row     <= '0;
            shadow      <= '0;
            row_mask    <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            scan_err    <= 1'b0;
            stalled     <= 1'b0;
            stall_tmr   <= '0;
        end else begin
            state       <= state_n;
            exp_row     <= exp_row_n;
            shadow      <= shadow_n;
            row_mask    <= mask_n;
            frame       <= frame_n;
            frame_valid <= fv_n;
            scan_err    <= err_n;
            stalled     <= stalled_n;
            if (changed)
                stall_tmr <= '0;
            else if (stall_tmr != TMR_MAX)
                stall_tmr <= stall_tmr + 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        exp_row_n = exp_row;
        shadow_n  = shadow;
        mask_n    = row_mask;
        frame_n   = frame;
        fv_n      = 1'b0;
        err_n     = scan_err;
        stalled_n = stalled;

        if (changed)
            stalled_n = 1'b0;
        else if (timeout)
            stalled_n = 1'b1;

        case (state)
            IDLE: begin
                mask_n = '0;
                if (en)
                    state_n = SYNC;
            end
            SYNC: begin
                if (strobe && row == '0) begin
                    shadow_n[0] = ~data;
                    mask_n      = 8'h01;
                    exp_row_n   = 3'd1;
                    state_n     = COLLECT;
                end
            end
            COLLECT: begin
                if (strobe) begin
                    if (row == exp_row) begin
                        shadow_n[row] = ~data;
                        mask_n[row]   = 1'b1;
                        exp_row_n     = row + 3'd1;
                        if (row == 3'(ROWS - 1))
                            state_n = COMMIT;
                    end else begin
                        err_n    = 1'b1;
                        mask_n   = '0;
                        shadow_n = '0;
                        state_n  = SYNC;
                    end
                end
            end
            COMMIT: begin
                frame_n = shadow;
                fv_n    = 1'b1;
                mask_n  = '0;
                state_n = SYNC;
            end
            default: state_n = IDLE;
        endcase

        // Timeout discards any same-cycle strobe; en=0 then overrides both.
        if (timeout) begin
            shadow_n  = shadow;
            exp_row_n = exp_row;
            err_n     = scan_err;
            mask_n    = '0;
            state_n   = SYNC;
        end
        if (!en) begin
            shadow_n  = shadow;
            exp_row_n = exp_row;
            err_n     = scan_err;
            frame_n   = frame;
            fv_n      = 1'b0;
            mask_n    = '0;
            state_n   = IDLE;
        end
    end

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed bench for matrix_scan_capture with STABLE_CYC=4, TIMEOUT_CYC=64.
module tb_matrix_scan_capture;
    import matrix_pkg::*;

    logic        clkF = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  scan_in;
    logic [7:0]  seg_in;
    logic [63:0] frame;
    logic        frame_valid;
    logic [7:0]  row_mask;
    logic        scan_err;
    logic        stalled;

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;

    always #5 clkF = ~clkF;

    matrix_scan_capture #(
        .STABLE_CYC  (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clkF        (clkF),
        .reset       (reset),
        .en          (en),
        .scan_in     (scan_in),
        .seg_in      (seg_in),
        .frame       (frame),
        .frame_valid (frame_valid),
        .row_mask    (row_mask),
        .scan_err    (scan_err),
        .stalled     (stalled)
    );

    always @(negedge clkF)
        if (frame_valid) fv_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clkF);
        #1;
    endtask

    task automatic drive(input int r, input logic [7:0] seg, input int n);
        scan_in = 3'(r);
        seg_in  = seg;
        tick(n);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] d2 [8] = '{8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E};

    initial begin
        reset   = 1'b1;
        en      = 1'b1;
        scan_in = 3'd0;
        seg_in  = 8'(~8'h01);
        tick(3);
        check("rst_frame",    frame,       64'h0);
        check("rst_fv",       frame_valid, 64'h0);
        check("rst_mask",     row_mask,    64'h0);
        check("rst_err",      scan_err,    64'h0);
        check("rst_stalled",  stalled,     64'h0);
        reset = 1'b0;

        // Clean diagonal pass, exact commit latency on row 7
        drive(0, 8'(~8'h01), 8);
        for (int r = 1; r < 4; r++) drive(r, 8'(~(8'h01 << r)), 8);
        check("t1_mask_0to3", row_mask, 64'h0F);
        for (int r = 4; r < 7; r++) drive(r, 8'(~(8'h01 << r)), 8);
        drive(7, 8'(~8'h80), 7);
        check("t1_fv_early", frame_valid, 64'h0);
        tick(1);
        check("t1_fv_pulse", frame_valid, 64'h1);
        check("t1_frame",    frame,       64'h8040201008040201);
        check("t1_mask_clr", row_mask,    64'h0);
        tick(1);
        check("t1_fv_drop",  frame_valid, 64'h0);
        check("t1_err",      scan_err,    64'h0);
        check("t1_fv_cnt",   fv_cnt,      64'd1);

        // Out-of-order row, then a clean pass with a seg glitch in row 2
        drive(0, 8'h00, 8);
        drive(1, 8'h00, 8);
        drive(2, 8'h00, 8);
        drive(4, 8'h00, 8);
        check("t2_err_set",  scan_err, 64'h1);
        check("t2_mask_clr", row_mask, 64'h0);
        drive(0, 8'(~d2[0]), 8);
        drive(1, 8'(~d2[1]), 8);
        drive(2, 8'h00, 2);
        drive(2, 8'(~d2[2]), 6);
        for (int r = 3; r < 7; r++) drive(r, 8'(~d2[r]), 8);
        drive(7, 8'(~d2[7]), 9);
        check("t2_fv_cnt",   fv_cnt,   64'd2);
        check("t2_frame",    frame,    64'h7E81F00FC33CFF00);
        check("t2_err_sticky", scan_err, 64'h1);

        // Minimum dwell samples every row; too-short dwell samples none
        for (int r = 0; r < 7; r++) drive(r, 8'(~(8'h80 >> r)), 5);
        drive(7, 8'(~8'h01), 9);
        check("t3_fv_cnt_min",  fv_cnt, 64'd3);
        check("t3_frame_min",   frame,  64'h0102040810204080);
        for (int r = 0; r < 7; r++) drive(r, 8'h00, 3);
        drive(7, 8'h00, 10);
        check("t3_fv_cnt_short", fv_cnt,   64'd3);
        check("t3_frame_hold",   frame,    64'h0102040810204080);
        check("t3_mask_short",   row_mask, 64'h0);

        // Stall on a held select
        drive(0, 8'h00, 8);
        drive(1, 8'h00, 8);
        drive(2, 8'h00, 8);
        drive(3, 8'(~8'h08), 8);
        check("t4_mask_pre",   row_mask, 64'h0F);
        tick(58);
        check("t4_not_yet",    stalled,  64'h0);
        tick(1);
        check("t4_stalled",    stalled,  64'h1);
        check("t4_mask_clr",   row_mask, 64'h0);
        tick(8);
        check("t4_saturate",   stalled,  64'h1);
        drive(4, 8'h00, 2);
        check("t4_stall_hold", stalled,  64'h1);
        tick(1);
        check("t4_stall_drop", stalled,  64'h0);

        // en dropped at the row-7 strobe
        for (int r = 0; r < 7; r++) drive(r, 8'h55, 8);
        drive(7, 8'h55, 6);
        en = 1'b0;
        tick(4);
        check("t5_fv_cnt",  fv_cnt,   64'd3);
        check("t5_frame",   frame,    64'h0102040810204080);
        check("t5_mask",    row_mask, 64'h0);
        en = 1'b1;
        tick(4);
        check("t5_mask_en", row_mask, 64'h0);
        drive(1, 8'h55, 8);
        check("t5_skip_r1", row_mask, 64'h0);
        drive(0, 8'h55, 8);
        check("t5_resync",  row_mask, 64'h01);

        // Reset mid-pass
        for (int r = 1; r < 5; r++) drive(r, 8'h55, 8);
        check("t6_mask_pre", row_mask, 64'h1F);
        drive(5, 8'h55, 3);
        reset = 1'b1;
        tick(1);
        check("t6_frame",   frame,       64'h0);
        check("t6_fv",      frame_valid, 64'h0);
        check("t6_mask",    row_mask,    64'h0);
        check("t6_err",     scan_err,    64'h0);
        check("t6_stalled", stalled,     64'h0);
        reset = 1'b0;
        tick(2);
        check("t6_err_post", scan_err,   64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
